bingo_pick_controller: RTL and testbench
========================================

Name: bingo_pick_controller

Overview:
- Sequences number entry for the Bingo game and shares the single keyboard front end between two players in strict alternation.
- Accumulates up to two decimal digits and validates the value on Enter: range 1..MAX_NUM, not already called.
- Hands an accepted pick to the game core through a valid/ready handshake, then passes the turn.
- Also enforces a per-turn timeout and keeps the called-number bitmap.

Parameters:
- MAX_NUM, 25, highest legal Bingo number (legal range 1..MAX_NUM, MAX_NUM ≤ 99).
- NUM_W, 7, width of the entry/pick value (holds 0..99).
- TIMEOUT_CYCLES, 500_000_000, clk cycles allowed in ENTRY before the turn is forfeited (5 s at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a game from IDLE.
- game_over  in  1  level from game core; forces IDLE.
- digit_valid  in  1  one-cycle strobe, a digit key was pressed.
- digit  in  4  digit value 0..9, qualified by digit_valid.
- enter_pulse  in  1  one-cycle Enter strobe.
- pick_ready  in  1  game core accepts a pick.
- pick_valid  out  1  accepted pick is presented.
- pick_num  out  NUM_W  picked number; stable while pick_valid.
- pick_player  out  1  player who made the pick.
- cur_player  out  1  player whose turn it is.
- entry_val  out  NUM_W  digits typed so far (display).
- entry_len  out  2  number of digits typed (0..2).
- err_pulse  out  1  one-cycle rejection strobe.
- err_code  out  2  0 none, 1 range, 2 duplicate, 3 timeout; held until next err_pulse.
- called_mask  out  MAX_NUM+1  bit k set when number k has been called; bit 0 is always 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timer cleared.
- States: IDLE, ENTRY, CHECK, COMMIT, ERROR, DONE.
- IDLE:
  - start → ENTRY.
  - On that transition: cur_player=0, called_mask cleared, entry cleared, timer loaded.
  - All other inputs are ignored.
- ENTRY, one event per cycle, priority enter_pulse > timeout > digit_valid:
  - digit_valid at len 0: val=digit, len=1.
  - digit_valid at len 1: val=val*10+digit, len=2.
  - digit_valid at len 2: restart, val=digit, len=1.
  - enter_pulse with len=0: ignored, no error.
  - enter_pulse with len>0: → CHECK; timer stops.
  - Timer expiry: err_pulse, err_code=3 (asserted in the ERROR cycle); cur_player toggles; entry cleared; timer reloaded; goes through ERROR.
- CHECK (one cycle):
  - val==0 or val>MAX_NUM → ERROR, code 1.
  - called_mask[val] set → ERROR, code 2.
  - Otherwise → COMMIT, with pick_num=val and pick_player=cur_player registered.
- ERROR (one cycle):
  - err_pulse=1.
  - Range/duplicate errors: same player keeps the turn, entry cleared, timer reloaded.
  - → ENTRY.
- COMMIT:
  - pick_valid=1 until the cycle pick_valid&&pick_ready; pick_num and pick_player held stable meanwhile.
  - On the handshake: called_mask[pick_num]<=1, cur_player toggles, entry cleared, timer reloaded.
  - → DONE if all bits 1..MAX_NUM are now set, else → ENTRY.
  - Timer is paused in COMMIT.
- DONE: busy=1, no picks accepted; leaves only via game_over or rst.
- Latency: enter_pulse sampled at edge N → CHECK at N+1 → pick_valid or err_pulse high from N+2.
- Keyboard inputs arriving in CHECK, COMMIT or ERROR are dropped, not queued.
- game_over (any state): → IDLE next edge. It aborts a pending pick (pick_valid drops, no mask update) and clears the entry. called_mask holds until the next start.
- start outside IDLE is ignored.
- rst mid-operation: immediate return to the reset values.
- Timer is a down-counter. Expiry fires when it reaches 0 while in ENTRY. Reload value is TIMEOUT_CYCLES-1.

Decomposition:
- Package bingo_pkg holds:
  - state enum (IDLE..DONE);
  - err_code constants ERR_NONE/ERR_RANGE/ERR_DUP/ERR_TIMEOUT;
  - MAX_NUM default;
  - player encoding (P0=0, P1=1).
- One sub-module, bingo_turn_timer, with ports clk, rst, load, run, expired; parameterised by TIMEOUT_CYCLES.
- Entry accumulation, validation and the bitmap stay in the top block.

Test Plan:
- start, digits 1,7, Enter → pick_valid at N+2 with pick_num=17, pick_player=0. Hold pick_ready low 3 cycles, pick_num stays stable. On handshake: called_mask[17]=1, cur_player=1.
- P1 types 1,7, Enter → err_pulse, err_code=2, cur_player stays 1, entry_len=0. Then 2,6 → err_code=1. Then 0 → err_code=1.
- Digits 1,2,3 → entry_val=3, entry_len=1. Enter with no digits → no pulse, state remains ENTRY.
- TIMEOUT_CYCLES=20, no keys → err_code=3 at cycle 21, cur_player toggles. Enter and expiry in the same cycle → Enter wins.
- MAX_NUM=3: pick 1,2,3 → DONE, further Enter is ignored. game_over → IDLE, busy=0.
- game_over during COMMIT with pick_ready low → pick_valid drops next cycle, mask unchanged. Async rst mid-ENTRY → all outputs 0 immediately.

Source files
------------

// File: rtl/bingo_pkg.sv
// Shared types and constants for the Bingo pick controller.
package bingo_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    ERROR  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Rejection reasons reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_DUP     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Highest legal Bingo number unless overridden
  localparam int MAX_NUM_DEFAULT = 25;

  // Player encoding
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/bingo_turn_timer.sv
// Per-turn down-counter. Loads TIMEOUT_CYCLES-1, counts while run is high,
// parks at zero and flags expiry while still running.
module bingo_turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count down while running; a load always wins and restarts the turn budget
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = run && (count == '0);

endmodule

// File: rtl/bingo_pick_controller.sv
// Bingo number entry sequencer: shares one keypad between two alternating
// players, accumulates up to two digits, validates on Enter and hands the
// accepted pick to the game core over valid/ready.
module bingo_pick_controller
  import bingo_pkg::*;
#(
  parameter int          MAX_NUM        = MAX_NUM_DEFAULT,
  parameter int          NUM_W          = 7,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             game_over,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             enter_pulse,
  input  logic             pick_ready,
  output logic             pick_valid,
  output logic [NUM_W-1:0] pick_num,
  output logic             pick_player,
  output logic             cur_player,
  output logic [NUM_W-1:0] entry_val,
  output logic [1:0]       entry_len,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [MAX_NUM:0] called_mask,
  output logic             busy
);

  localparam int MW = MAX_NUM + 1;
  localparam logic [MW-1:0] ONE_HOT0 = MW'(1);
  // Every legal number called; bit 0 never participates
  localparam logic [MW-1:0] FULL = {{MAX_NUM{1'b1}}, 1'b0};

  // Append one decimal digit to the running entry
  function automatic logic [NUM_W-1:0] dec_append(input logic [NUM_W-1:0] v,
                                                  input logic [3:0]       d);
    return v * NUM_W'(10) + NUM_W'(d);
  endfunction

  state_t           state;
  state_t           next_state;
  logic             timer_load;
  logic             timer_run;
  logic             timer_expired;
  logic             entry_clear;
  logic             digit_take;
  logic             pick_latch;
  logic             handshake;
  logic             game_init;
  logic             player_toggle;
  logic             err_set;
  logic [1:0]       err_next;
  logic [NUM_W-1:0] entry_next;
  logic [1:0]       len_next;
  logic [MW-1:0]    entry_onehot;
  logic [MW-1:0]    pick_onehot;
  logic             entry_bad_range;
  logic             entry_called;
  logic             all_called_after;

  assign timer_run        = (state == ENTRY);
  assign entry_onehot     = ONE_HOT0 << entry_val;
  assign pick_onehot      = ONE_HOT0 << pick_num;
  assign entry_bad_range  = (entry_val == '0) || (entry_val > NUM_W'(MAX_NUM));
  assign entry_called     = |(called_mask & entry_onehot);
  assign all_called_after = (((called_mask | pick_onehot) & FULL) == FULL);

  bingo_turn_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Next entry value/length for an accepted digit; a third digit restarts entry
  always_comb begin
    entry_next = NUM_W'(digit);
    len_next   = 2'd1;
    if (entry_len == 2'd1) begin
      entry_next = dec_append(entry_val, digit);
      len_next   = 2'd2;
    end else begin
      entry_next = NUM_W'(digit);
      len_next   = 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control; game_over overrides every state
  always_comb begin
    next_state    = state;
    timer_load    = 1'b0;
    entry_clear   = 1'b0;
    digit_take    = 1'b0;
    pick_latch    = 1'b0;
    handshake     = 1'b0;
    game_init     = 1'b0;
    player_toggle = 1'b0;
    err_set       = 1'b0;
    err_next      = ERR_NONE;
    if (game_over) begin
      next_state  = IDLE;
      entry_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state  = ENTRY;
            game_init   = 1'b1;
            entry_clear = 1'b1;
            timer_load  = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
        ENTRY: begin
          if (enter_pulse) begin
            if (entry_len != 2'd0) begin
              next_state = CHECK;
            end else begin
              next_state = ENTRY;
            end
          end else if (timer_expired) begin
            next_state    = ERROR;
            err_set       = 1'b1;
            err_next      = ERR_TIMEOUT;
            player_toggle = 1'b1;
            entry_clear   = 1'b1;
          end else if (digit_valid) begin
            next_state = ENTRY;
            digit_take = 1'b1;
          end else begin
            next_state = ENTRY;
          end
        end
        CHECK: begin
          if (entry_bad_range) begin
            next_state  = ERROR;
            err_set     = 1'b1;
            err_next    = ERR_RANGE;
            entry_clear = 1'b1;
          end else if (entry_called) begin
            next_state  = ERROR;
            err_set     = 1'b1;
            err_next    = ERR_DUP;
            entry_clear = 1'b1;
          end else begin
            next_state = COMMIT;
            pick_latch = 1'b1;
          end
        end
        COMMIT: begin
          if (pick_ready) begin
            handshake     = 1'b1;
            player_toggle = 1'b1;
            entry_clear   = 1'b1;
            timer_load    = 1'b1;
            if (all_called_after) begin
              next_state = DONE;
            end else begin
              next_state = ENTRY;
            end
          end else begin
            next_state = COMMIT;
          end
        end
        ERROR: begin
          next_state = ENTRY;
          timer_load = 1'b1;
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Entry accumulator shown on the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_val <= '0;
      entry_len <= 2'd0;
    end else if (entry_clear) begin
      entry_val <= '0;
      entry_len <= 2'd0;
    end else if (digit_take) begin
      entry_val <= entry_next;
      entry_len <= len_next;
    end else begin
      entry_val <= entry_val;
      entry_len <= entry_len;
    end
  end

  // Turn ownership: player 0 opens each game, turns alternate afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_player <= P0;
    end else if (game_init) begin
      cur_player <= P0;
    end else if (player_toggle) begin
      cur_player <= ~cur_player;
    end else begin
      cur_player <= cur_player;
    end
  end

  // Called-number bitmap, updated only on a completed handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      called_mask <= '0;
    end else if (game_init) begin
      called_mask <= '0;
    end else if (handshake) begin
      called_mask <= (called_mask | pick_onehot) & FULL;
    end else begin
      called_mask <= called_mask;
    end
  end

  // Pick payload captured on validation and held through COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pick_num    <= '0;
      pick_player <= P0;
    end else if (pick_latch) begin
      pick_num    <= entry_val;
      pick_player <= cur_player;
    end else begin
      pick_num    <= pick_num;
      pick_player <= pick_player;
    end
  end

  // Error strobe for the ERROR cycle; the code persists until the next strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (err_set) begin
      err_pulse <= 1'b1;
      err_code  <= err_next;
    end else begin
      err_pulse <= 1'b0;
      err_code  <= err_code;
    end
  end

  // State-decoded flags registered alongside the state transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pick_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pick_valid <= (next_state == COMMIT);
      busy       <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_bingo_pick_controller.sv
// Self-checking bench for bingo_pick_controller: directed scenarios plus
// randomized turns compared against a turn-level reference model.
module tb_bingo_pick_controller;

  localparam int MAXN = 25;
  localparam int TMO  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          game_over;
  logic          digit_valid;
  logic [3:0]    digit;
  logic          enter_pulse;
  logic          pick_ready;
  logic          pick_valid;
  logic [6:0]    pick_num;
  logic          pick_player;
  logic          cur_player;
  logic [6:0]    entry_val;
  logic [1:0]    entry_len;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [MAXN:0] called_mask;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_called [0:MAXN];
  logic       m_player;
  logic [1:0] m_err;

  bingo_pick_controller #(
    .MAX_NUM        (MAXN),
    .NUM_W          (7),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .game_over   (game_over),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter_pulse (enter_pulse),
    .pick_ready  (pick_ready),
    .pick_valid  (pick_valid),
    .pick_num    (pick_num),
    .pick_player (pick_player),
    .cur_player  (cur_player),
    .entry_val   (entry_val),
    .entry_len   (entry_len),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .called_mask (called_mask),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAXN:0] model_mask();
    logic [MAXN:0] v;
    v = '0;
    for (int k = 1; k <= MAXN; k++) if (m_called[k]) v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit model_all_called();
    int n;
    n = 0;
    for (int k = 1; k <= MAXN; k++) n += int'(m_called[k]);
    return (n == MAXN);
  endfunction

  task automatic model_new_game();
    for (int k = 0; k <= MAXN; k++) m_called[k] = 1'b0;
    m_player = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int d);
    digit_valid = 1'b1;
    digit       = 4'(d);
    tick();
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic enter();
    enter_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
  endtask

  // One player turn: type n digits, press Enter, check the outcome the
  // game rules predict. Ends on the edge that reloads the turn timer.
  task automatic play_entry(input int n, input int d0, input int d1, input int d2,
                            input int gap_max, input int idle_before, input int ready_delay);
    int         ds [3];
    int         val;
    int         glen;
    logic [1:0] exp_code;
    ds[0] = d0; ds[1] = d1; ds[2] = d2;
    val = 0;
    repeat (idle_before) tick();
    for (int i = 0; i < n; i++) begin
      key(ds[i]);
      glen = (i % 2) + 1;
      val  = (glen == 1) ? ds[i] : ds[i-1] * 10 + ds[i];
      chk("entry_len", entry_len, glen);
      chk("entry_val", entry_val, val);
      if (i < n - 1) repeat ($urandom_range(gap_max, 0)) tick();
    end
    enter();
    if (n == 0) begin
      chk("empty_enter_len", entry_len, 0);
      tick();
      chk("empty_enter_err", err_pulse, 0);
      chk("empty_enter_valid", pick_valid, 0);
      chk("empty_enter_busy", busy, 1);
      chk("empty_enter_code", err_code, m_err);
      return;
    end
    chk("check_cycle_valid", pick_valid, 0);
    chk("check_cycle_err", err_pulse, 0);
    tick();
    if (val < 1 || val > MAXN) exp_code = 2'd1;
    else if (m_called[val]) exp_code = 2'd2;
    else exp_code = 2'd0;
    if (exp_code != 2'd0) begin
      chk("err_pulse", err_pulse, 1);
      chk("err_code", err_code, exp_code);
      chk("err_player", cur_player, m_player);
      chk("err_entry_len", entry_len, 0);
      chk("err_no_valid", pick_valid, 0);
      m_err = exp_code;
      tick();
      chk("err_pulse_one_cycle", err_pulse, 0);
      chk("err_code_held", err_code, exp_code);
    end else begin
      chk("pick_valid", pick_valid, 1);
      chk("pick_num", pick_num, val);
      chk("pick_player", pick_player, m_player);
      for (int w = 0; w < ready_delay; w++) begin
        tick();
        chk("hold_valid", pick_valid, 1);
        chk("hold_num", pick_num, val);
        chk("hold_player", pick_player, m_player);
      end
      pick_ready = 1'b1;
      tick();
      pick_ready = 1'b0;
      m_called[val] = 1'b1;
      m_player = ~m_player;
      chk("hs_valid_drop", pick_valid, 0);
      chk("hs_mask", called_mask, model_mask());
      chk("hs_player", cur_player, m_player);
      chk("hs_entry_len", entry_len, 0);
      chk("hs_busy", busy, 1);
    end
  endtask

  initial begin
    int cnt;
    int seen;
    int pick_d;
    int turns;
    int n;

    rst = 1'b1; start = 1'b0; game_over = 1'b0; digit_valid = 1'b0;
    digit = 4'd0; enter_pulse = 1'b0; pick_ready = 1'b0;
    m_err = 2'd0;
    model_new_game();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_pick_valid", pick_valid, 0);
    chk("rst_mask", called_mask, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_entry_len", entry_len, 0);
    rst = 1'b0;
    tick();

    // IDLE ignores keys
    key(5);
    chk("idle_ignores_digit", entry_len, 0);
    chk("idle_busy", busy, 0);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_player", cur_player, 0);

    // Directed turns: good pick, duplicate, out of range, zero, empty Enter, restart
    play_entry(2, 1, 7, 0, 0, 0, 3);
    play_entry(2, 1, 7, 0, 0, 0, 0);
    play_entry(2, 2, 6, 0, 0, 0, 0);
    play_entry(1, 0, 0, 0, 0, 0, 0);
    play_entry(0, 0, 0, 0, 0, 0, 0);
    play_entry(3, 1, 2, 3, 0, 0, 0);

    // Timeout: a digit does not refresh the timer; expiry 20 edges after reload
    key(4);
    cnt = 1;
    while (!err_pulse && cnt < 100) begin
      tick();
      cnt++;
    end
    m_player = ~m_player;
    chk("timeout_latency", cnt, TMO);
    chk("timeout_code", err_code, 3);
    chk("timeout_player", cur_player, m_player);
    chk("timeout_entry_len", entry_len, 0);
    m_err = 2'd3;
    tick();
    chk("timeout_pulse_one_cycle", err_pulse, 0);

    // Enter in the same cycle as expiry: Enter is taken
    pick_d = 9;
    for (int k = 9; k >= 1; k--) if (!m_called[k]) pick_d = k;
    play_entry(1, pick_d, 0, 0, 0, TMO - 2, 0);

    // Random turns, then fill whatever is left to reach DONE
    turns = 0;
    while (!model_all_called() && turns < 60) begin
      n = $urandom_range(3, 1);
      play_entry(n, $urandom_range(2, 0), $urandom_range(9, 0), $urandom_range(9, 0),
                 2, 0, $urandom_range(3, 0));
      turns++;
    end
    for (int k = 1; k <= MAXN; k++) begin
      if (!m_called[k]) play_entry(2, k / 10, k % 10, 0, 0, 0, $urandom_range(2, 0));
    end
    chk("done_mask_full", called_mask, model_mask());

    // DONE: no entry, no picks, no timeouts
    key(4); key(2); enter();
    chk("done_entry_len", entry_len, 0);
    seen = 0;
    repeat (2 * TMO) begin
      tick();
      seen += int'(err_pulse) + int'(pick_valid);
    end
    chk("done_quiet", seen, 0);
    chk("done_busy", busy, 1);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk("game_over_busy", busy, 0);
    chk("game_over_mask_holds", called_mask, model_mask());

    // New game, then abort a pending pick
    start = 1'b1; tick(); start = 1'b0;
    model_new_game();
    chk("restart_mask", called_mask, 0);
    chk("restart_player", cur_player, 0);
    key(5); enter(); tick();
    chk("abort_pick_valid", pick_valid, 1);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk("abort_valid_drop", pick_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mask", called_mask, 0);
    chk("abort_entry_len", entry_len, 0);

    // start outside IDLE is ignored
    start = 1'b1; tick(); start = 1'b0;
    key(1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored_len", entry_len, 1);
    chk("start_ignored_val", entry_val, 1);

    // Asynchronous reset mid-entry
    key(2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_entry_len", entry_len, 0);
    chk("arst_entry_val", entry_val, 0);
    chk("arst_err_code", err_code, 0);
    chk("arst_mask", called_mask, 0);
    chk("arst_pick_num", pick_num, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
